antic_dma_fetcher: RTL and testbench

- Parametrised DMA fetch engine for the ANTIC display path.
- Fetches display-list instructions with their operands (LMS, JMP, JVB) and playfield bytes addressed by the memory scan counter (MSR).
- Playfield bytes go into an internal line buffer read by the pixel pipeline.
- Arbitrates the bus against the CPU with a req/grant handshake and drives halt_L.
- Applies the ANTIC address-wrap rules: display-list counter wraps within 1K, MSR wraps within 4K.

---
 rtl/antic_dma_fetcher_if.sv | 24 ++
 rtl/antic_dma_fetcher.sv | 299 +++++++++++++++++++++++++++++
 tb/tb_antic_dma_fetcher.sv | 422 ++++++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/antic_dma_fetcher_if.sv
// Memory-side request/grant bus between the ANTIC DMA fetcher and the bus arbiter.
interface antic_dma_fetcher_if #(
   parameter int ADDR_W = 16,
   parameter int DATA_W = 8
) ();
   logic              mem_req;
   logic [ADDR_W-1:0] mem_addr;
   logic              mem_grant;
   logic [DATA_W-1:0] mem_data;

   modport master (
      output mem_req,
      output mem_addr,
      input  mem_grant,
      input  mem_data
   );

   modport slave (
      input  mem_req,
      input  mem_addr,
      output mem_grant,
      output mem_data
   );
endinterface

// File: rtl/antic_dma_fetcher.sv
// ANTIC DMA fetch engine: display-list instruction/operand fetch and playfield
// line fetch into a local line buffer, sharing the bus with the CPU via req/grant.
//
// state        | meaning
// -------------+----------------------------------------------------------
// S_IDLE       | no bus activity; arbitrates start_dl over start_line
// S_FETCH_IR   | fetching the display-list opcode at dlist_ptr
// S_FETCH_LO   | fetching operand low byte (LMS / JMP / JVB)
// S_FETCH_HI   | fetching operand high byte; commits LMS / JMP on grant
// S_FETCH_LINE | fetching playfield bytes at msr into the line buffer
module antic_dma_fetcher #(
   parameter int ADDR_W        = 16,
   parameter int DATA_W        = 8,
   parameter int LINEBUF_DEPTH = 48,
   parameter int DL_WRAP_BITS  = 10,
   parameter int MSR_WRAP_BITS = 12
) (
   input  logic                Fphi0,
   input  logic                rst,
   input  logic                start_dl,
   input  logic                start_line,
   input  logic [6:0]          line_bytes,
   input  logic                dlist_load,
   input  logic [ADDR_W-1:0]   dlist_init,
   input  logic                vblank,
   antic_dma_fetcher_if.master mem,
   output logic                halt_L,
   output logic                busy,
   output logic [7:0]          ir,
   output logic                ir_valid,
   output logic                dli,
   output logic                wait_vbl,
   output logic [ADDR_W-1:0]   dlist_ptr,
   output logic [ADDR_W-1:0]   msr,
   input  logic [5:0]          buf_rd_addr,
   output logic [DATA_W-1:0]   buf_rd_data,
   output logic                line_done
);

   localparam logic [2:0] S_IDLE       = 3'd0;
   localparam logic [2:0] S_FETCH_IR   = 3'd1;
   localparam logic [2:0] S_FETCH_LO   = 3'd2;
   localparam logic [2:0] S_FETCH_HI   = 3'd3;
   localparam logic [2:0] S_FETCH_LINE = 3'd4;

   localparam int IDX_W = (LINEBUF_DEPTH > 1) ? $clog2(LINEBUF_DEPTH) : 1;

   function automatic logic [ADDR_W-1:0] dl_inc(input logic [ADDR_W-1:0] a);
      logic [ADDR_W-1:0] r;
      r = a;
      r[DL_WRAP_BITS-1:0] = a[DL_WRAP_BITS-1:0] + 1'b1;
      return r;
   endfunction

   function automatic logic [ADDR_W-1:0] msr_inc(input logic [ADDR_W-1:0] a);
      logic [ADDR_W-1:0] r;
      r = a;
      r[MSR_WRAP_BITS-1:0] = a[MSR_WRAP_BITS-1:0] + 1'b1;
      return r;
   endfunction

   // JMP/JVB (mode 1) and LMS (bit 6 on a playfield mode) carry a 2-byte operand
   function automatic logic has_operands(input logic [7:0] op);
      return (op[3:0] == 4'd1) || ((op[3:0] >= 4'd2) && op[6]);
   endfunction

   logic [2:0]          state_q,     state_d;
   logic                mem_req_q,   mem_req_d;
   logic [ADDR_W-1:0]   mem_addr_q,  mem_addr_d;
   logic [ADDR_W-1:0]   dlist_ptr_q, dlist_ptr_d;
   logic [ADDR_W-1:0]   msr_q,       msr_d;
   logic [7:0]          ir_q,        ir_d;
   logic [DATA_W-1:0]   lo_q,        lo_d;
   logic                ir_valid_q,  ir_valid_d;
   logic                dli_q,       dli_d;
   logic                wait_vbl_q,  wait_vbl_d;
   logic                line_done_q, line_done_d;
   logic                pend_q,      pend_d;
   logic [ADDR_W-1:0]   pend_ptr_q,  pend_ptr_d;
   logic [6:0]          cnt_q,       cnt_d;
   logic [IDX_W-1:0]    idx_q,       idx_d;
   logic [DATA_W-1:0]   buf_rd_data_q, buf_rd_data_d;

   logic [DATA_W-1:0]   buf_mem [LINEBUF_DEPTH];
   logic                buf_we;
   logic [IDX_W-1:0]    buf_wa;
   logic [DATA_W-1:0]   buf_wd;

   logic                grant;
   logic [ADDR_W-1:0]   tgt;
   logic                pend_hit;
   logic [ADDR_W-1:0]   pend_val;
   logic [6:0]          n_line;
   logic [IDX_W-1:0]    rd_idx;

   always_comb begin
      state_d     = state_q;
      mem_req_d   = mem_req_q;
      mem_addr_d  = mem_addr_q;
      dlist_ptr_d = dlist_ptr_q;
      msr_d       = msr_q;
      ir_d        = ir_q;
      lo_d        = lo_q;
      ir_valid_d  = 1'b0;
      dli_d       = 1'b0;
      wait_vbl_d  = wait_vbl_q;
      line_done_d = 1'b0;
      pend_d      = pend_q;
      pend_ptr_d  = pend_ptr_q;
      cnt_d       = cnt_q;
      idx_d       = idx_q;
      buf_we      = 1'b0;
      buf_wa      = idx_q;
      buf_wd      = mem.mem_data;

      grant    = mem_req_q & mem.mem_grant;
      tgt      = ADDR_W'({mem.mem_data, lo_q});
      pend_hit = pend_q | dlist_load;
      pend_val = dlist_load ? dlist_init : pend_ptr_q;
      n_line   = (int'(line_bytes) > LINEBUF_DEPTH) ? 7'(LINEBUF_DEPTH) : line_bytes;

      if (vblank) wait_vbl_d = 1'b0;

      case (state_q)
         S_IDLE: begin
            if (dlist_load) begin
               dlist_ptr_d = dlist_init;
               wait_vbl_d  = 1'b0;
            end
            if (start_dl && !wait_vbl_q) begin
               state_d    = S_FETCH_IR;
               mem_req_d  = 1'b1;
               mem_addr_d = dlist_load ? dlist_init : dlist_ptr_q;
            end else if (start_line) begin
               if (n_line == 7'd0) begin
                  line_done_d = 1'b1;
               end else begin
                  state_d    = S_FETCH_LINE;
                  mem_req_d  = 1'b1;
                  mem_addr_d = msr_q;
                  cnt_d      = n_line;
                  idx_d      = '0;
               end
            end
         end

         S_FETCH_IR: begin
            if (dlist_load) begin
               pend_d     = 1'b1;
               pend_ptr_d = dlist_init;
            end
            if (grant) begin
               ir_d        = mem.mem_data[7:0];
               dlist_ptr_d = dl_inc(dlist_ptr_q);
               if (has_operands(mem.mem_data[7:0])) begin
                  state_d    = S_FETCH_LO;
                  mem_addr_d = dl_inc(dlist_ptr_q);
               end else begin
                  state_d    = S_IDLE;
                  mem_req_d  = 1'b0;
                  ir_valid_d = 1'b1;
                  dli_d      = mem.mem_data[7];
                  if (pend_hit) begin
                     dlist_ptr_d = pend_val;
                     wait_vbl_d  = 1'b0;
                     pend_d      = 1'b0;
                  end
               end
            end
         end

         S_FETCH_LO: begin
            if (dlist_load) begin
               pend_d     = 1'b1;
               pend_ptr_d = dlist_init;
            end
            if (grant) begin
               lo_d        = mem.mem_data;
               dlist_ptr_d = dl_inc(dlist_ptr_q);
               mem_addr_d  = dl_inc(dlist_ptr_q);
               state_d     = S_FETCH_HI;
            end
         end

         S_FETCH_HI: begin
            if (dlist_load) begin
               pend_d     = 1'b1;
               pend_ptr_d = dlist_init;
            end
            if (grant) begin
               dlist_ptr_d = dl_inc(dlist_ptr_q);
               state_d     = S_IDLE;
               mem_req_d   = 1'b0;
               ir_valid_d  = 1'b1;
               dli_d       = ir_q[7];
               if (ir_q[3:0] == 4'd1) begin
                  dlist_ptr_d = tgt;
                  if (ir_q[6]) wait_vbl_d = 1'b1;
               end else begin
                  msr_d = tgt;
               end
               // a host reload outranks whatever jump target the list supplied
               if (pend_hit) begin
                  dlist_ptr_d = pend_val;
                  wait_vbl_d  = 1'b0;
                  pend_d      = 1'b0;
               end
            end
         end

         S_FETCH_LINE: begin
            if (dlist_load) begin
               dlist_ptr_d = dlist_init;
               wait_vbl_d  = 1'b0;
            end
            if (grant) begin
               buf_we = 1'b1;
               msr_d  = msr_inc(msr_q);
               idx_d  = idx_q + 1'b1;
               cnt_d  = cnt_q - 7'd1;
               if (cnt_q == 7'd1) begin
                  state_d     = S_IDLE;
                  mem_req_d   = 1'b0;
                  line_done_d = 1'b1;
               end else begin
                  mem_addr_d = msr_inc(msr_q);
               end
            end
         end

         default: begin
            state_d   = S_IDLE;
            mem_req_d = 1'b0;
         end
      endcase
   end

   always_ff @(posedge Fphi0) begin
      if (rst) begin
         state_q     <= S_IDLE;
         mem_req_q   <= 1'b0;
         mem_addr_q  <= '0;
         dlist_ptr_q <= '0;
         msr_q       <= '0;
         ir_q        <= '0;
         lo_q        <= '0;
         ir_valid_q  <= 1'b0;
         dli_q       <= 1'b0;
         wait_vbl_q  <= 1'b0;
         line_done_q <= 1'b0;
         pend_q      <= 1'b0;
         pend_ptr_q  <= '0;
         cnt_q       <= '0;
         idx_q       <= '0;
      end else begin
         state_q     <= state_d;
         mem_req_q   <= mem_req_d;
         mem_addr_q  <= mem_addr_d;
         dlist_ptr_q <= dlist_ptr_d;
         msr_q       <= msr_d;
         ir_q        <= ir_d;
         lo_q        <= lo_d;
         ir_valid_q  <= ir_valid_d;
         dli_q       <= dli_d;
         wait_vbl_q  <= wait_vbl_d;
         line_done_q <= line_done_d;
         pend_q      <= pend_d;
         pend_ptr_q  <= pend_ptr_d;
         cnt_q       <= cnt_d;
         idx_q       <= idx_d;
      end
   end

   // Read port samples before the write lands, so a same-index read sees old data
   always_comb begin
      rd_idx        = IDX_W'(buf_rd_addr);
      buf_rd_data_d = '0;
      if (int'(buf_rd_addr) < LINEBUF_DEPTH) buf_rd_data_d = buf_mem[rd_idx];
   end

   always_ff @(posedge Fphi0) begin
      buf_rd_data_q <= buf_rd_data_d;
      if (buf_we) buf_mem[buf_wa] <= buf_wd;
   end

   assign mem.mem_req  = mem_req_q;
   assign mem.mem_addr = mem_addr_q;
   assign halt_L       = ~mem_req_q;
   assign busy         = (state_q != S_IDLE);
   assign ir           = ir_q;
   assign ir_valid     = ir_valid_q;
   assign dli          = dli_q;
   assign wait_vbl     = wait_vbl_q;
   assign dlist_ptr    = dlist_ptr_q;
   assign msr          = msr_q;
   assign buf_rd_data  = buf_rd_data_q;
   assign line_done    = line_done_q;

endmodule

// File: tb/tb_antic_dma_fetcher.sv
// Bench for antic_dma_fetcher: directed vector table, multi-cycle corner sequences,
// and randomized display-list / line fetches against a memory-image reference model.
module tb_antic_dma_fetcher;

   logic        Fphi0 = 1'b0;
   logic        rst, start_dl, start_line, dlist_load, vblank;
   logic [6:0]  line_bytes;
   logic [15:0] dlist_init;
   logic        halt_L, busy, ir_valid, dli, wait_vbl, line_done;
   logic [7:0]  ir;
   logic [15:0] dlist_ptr, msr;
   logic [5:0]  buf_rd_addr;
   logic [7:0]  buf_rd_data;

   antic_dma_fetcher_if #(.ADDR_W(16), .DATA_W(8)) mif ();

   antic_dma_fetcher dut (
      .Fphi0       (Fphi0),
      .rst         (rst),
      .start_dl    (start_dl),
      .start_line  (start_line),
      .line_bytes  (line_bytes),
      .dlist_load  (dlist_load),
      .dlist_init  (dlist_init),
      .vblank      (vblank),
      .mem         (mif),
      .halt_L      (halt_L),
      .busy        (busy),
      .ir          (ir),
      .ir_valid    (ir_valid),
      .dli         (dli),
      .wait_vbl    (wait_vbl),
      .dlist_ptr   (dlist_ptr),
      .msr         (msr),
      .buf_rd_addr (buf_rd_addr),
      .buf_rd_data (buf_rd_data),
      .line_done   (line_done)
   );

   always #5 Fphi0 = ~Fphi0;

   int          checks = 0;
   int          failures = 0;
   logic [7:0]  mem_img [65536];
   logic [15:0] fetch_log [$];
   logic [15:0] exp_addrs [$];
   logic [7:0]  exp_buf [48];
   int          gmode = 1;
   bit          gphase = 1'b0;
   bit          prev_wait = 1'b0;
   logic [15:0] prev_addr = '0;
   int          iv_cnt, dli_cnt, ld_cnt;
   logic [15:0] mptr, mmsr;
   logic        mwait;

   typedef struct {
      logic [15:0] ptr;
      logic [7:0]  op, lo, hi;
      int          mode;
      logic [7:0]  e_ir;
      logic        e_dli;
      logic [15:0] e_ptr, e_msr;
      logic        e_wait;
      int          e_nf;
      logic [15:0] e_last;
   } vec_t;
   vec_t vt [8];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%0h required=%0h", name, act, exp);
      end
   endtask

   function automatic logic [15:0] nx_dl(input logic [15:0] p);
      return (p & 16'hFC00) | ((p + 16'd1) & 16'h03FF);
   endfunction

   function automatic logic [15:0] nx_msr(input logic [15:0] p);
      return (p & 16'hF000) | ((p + 16'd1) & 16'h0FFF);
   endfunction

   // One clock: act as the bus slave for the current cycle, then sample after the edge
   task automatic step();
      bit g;
      if (mif.mem_req) begin
         if (prev_wait) check("addr_stable", mif.mem_addr, prev_addr);
         case (gmode)
            1:       g = 1'b1;
            2:       begin g = gphase; gphase = ~gphase; end
            default: g = bit'($urandom_range(0, 1));
         endcase
         mif.mem_grant = g;
         mif.mem_data  = g ? mem_img[mif.mem_addr] : 8'($urandom);
         if (g) fetch_log.push_back(mif.mem_addr);
         prev_wait = !g;
         prev_addr = mif.mem_addr;
      end else begin
         mif.mem_grant = 1'($urandom_range(0, 1));
         mif.mem_data  = 8'($urandom);
         prev_wait     = 1'b0;
      end
      @(posedge Fphi0);
      #1;
      if (halt_L !== ~mif.mem_req) check("halt_L", halt_L, ~mif.mem_req);
      if (ir_valid) iv_cnt++;
      if (dli) begin
         dli_cnt++;
         check("dli_with_ir_valid", ir_valid, 1);
      end
      if (line_done) begin
         ld_cnt++;
         check("line_done_idle", busy, 0);
      end
   endtask

   task automatic wait_idle(input int budget);
      int n = 0;
      while (busy && n < budget) begin
         step();
         n++;
      end
      if (busy) check("idle_timeout", busy, 0);
      step();
   endtask

   task automatic clear_obs();
      iv_cnt = 0; dli_cnt = 0; ld_cnt = 0;
      fetch_log.delete();
   endtask

   task automatic load_ptr(input logic [15:0] v);
      dlist_load = 1'b1; dlist_init = v;
      step();
      dlist_load = 1'b0;
   endtask

   task automatic do_dl();
      clear_obs();
      start_dl = 1'b1;
      step();
      start_dl = 1'b0;
      check("req_after_start_dl", mif.mem_req, 1);
      wait_idle(400);
   endtask

   task automatic do_line(input int len);
      clear_obs();
      line_bytes = 7'(len);
      start_line = 1'b1;
      step();
      start_line = 1'b0;
      if (len == 0) begin
         check("zero_line_done", line_done, 1);
         check("zero_line_req", mif.mem_req, 0);
      end else begin
         check("req_after_start_line", mif.mem_req, 1);
      end
      wait_idle(600);
   endtask

   task automatic read_buf(input int k, output logic [7:0] d);
      buf_rd_addr = 6'(k);
      step();
      d = buf_rd_data;
   endtask

   task automatic check_log(input string name);
      check({name, "_nfetch"}, fetch_log.size(), exp_addrs.size());
      for (int i = 0; i < exp_addrs.size() && i < fetch_log.size(); i++)
         check({name, "_addr"}, fetch_log[i], exp_addrs[i]);
   endtask

   // Reference: a display-list instruction as a walk over the memory image
   task automatic model_dl(output logic [7:0] op);
      logic [15:0] p, t;
      logic [7:0]  lo, hi;
      int          nib;
      bit          ops;
      exp_addrs.delete();
      p = mptr;
      exp_addrs.push_back(p);
      op = mem_img[p];
      p = nx_dl(p);
      nib = int'(op) % 16;
      ops = (nib == 1) || (nib >= 2 && ((int'(op) / 64) % 2 == 1));
      if (ops) begin
         exp_addrs.push_back(p); lo = mem_img[p]; p = nx_dl(p);
         exp_addrs.push_back(p); hi = mem_img[p]; p = nx_dl(p);
         t = 16'(int'(hi) * 256 + int'(lo));
         if (nib == 1) begin
            p = t;
            if (op >= 8'h40 && op < 8'h80 || op >= 8'hC0) mwait = 1'b1;
         end else begin
            mmsr = t;
         end
      end
      mptr = p;
   endtask

   task automatic model_line(input int len);
      int n;
      n = (len > 48) ? 48 : len;
      exp_addrs.delete();
      for (int k = 0; k < n; k++) begin
         exp_addrs.push_back(mmsr);
         exp_buf[k] = mem_img[mmsr];
         mmsr = nx_msr(mmsr);
      end
   endtask

   initial begin
      logic [7:0]  d, op;
      logic [15:0] a;
      logic [15:0] four [4];
      int          n, len, sel;

      #5000000;
      $display("FAIL watchdog actual=running required=finished");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [7:0]  d, op;
      logic [15:0] four [4];
      int          n, len, sel;

      vt[0] = '{16'h2000, 8'h02, 8'h00, 8'h00, 1, 8'h02, 1'b0, 16'h2001, 16'h0000, 1'b0, 1, 16'h2000};
      vt[1] = '{16'h2001, 8'hC4, 8'h00, 8'h40, 2, 8'hC4, 1'b1, 16'h2004, 16'h4000, 1'b0, 3, 16'h2003};
      vt[2] = '{16'h23FF, 8'h02, 8'h00, 8'h00, 1, 8'h02, 1'b0, 16'h2000, 16'h4000, 1'b0, 1, 16'h23FF};
      vt[3] = '{16'h07FF, 8'h8F, 8'h00, 8'h00, 3, 8'h8F, 1'b1, 16'h0400, 16'h4000, 1'b0, 1, 16'h07FF};
      vt[4] = '{16'h3000, 8'h01, 8'h34, 8'h12, 3, 8'h01, 1'b0, 16'h1234, 16'h4000, 1'b0, 3, 16'h3002};
      vt[5] = '{16'h23FE, 8'h4D, 8'hFE, 8'h4F, 2, 8'h4D, 1'b0, 16'h2001, 16'h4FFE, 1'b0, 3, 16'h2000};
      vt[6] = '{16'h1000, 8'h70, 8'h00, 8'h00, 1, 8'h70, 1'b0, 16'h1001, 16'h4FFE, 1'b0, 1, 16'h1000};
      vt[7] = '{16'h2004, 8'h41, 8'h00, 8'h30, 1, 8'h41, 1'b0, 16'h3000, 16'h4FFE, 1'b1, 3, 16'h2006};

      for (int i = 0; i < 65536; i++) mem_img[i] = 8'($urandom);
      rst = 1'b1; start_dl = 1'b0; start_line = 1'b0; dlist_load = 1'b0; vblank = 1'b0;
      line_bytes = '0; dlist_init = '0; buf_rd_addr = '0;
      mif.mem_grant = 1'b0; mif.mem_data = '0;

      step(); step();
      check("rst_mem_req", mif.mem_req, 0);
      check("rst_mem_addr", mif.mem_addr, 0);
      check("rst_halt_L", halt_L, 1);
      check("rst_busy", busy, 0);
      check("rst_ir", ir, 0);
      check("rst_ir_valid", ir_valid, 0);
      check("rst_dli", dli, 0);
      check("rst_wait_vbl", wait_vbl, 0);
      check("rst_dlist_ptr", dlist_ptr, 0);
      check("rst_msr", msr, 0);
      check("rst_line_done", line_done, 0);
      rst = 1'b0;
      step();

      foreach (vt[i]) begin
         load_ptr(vt[i].ptr);
         mem_img[vt[i].ptr] = vt[i].op;
         mem_img[nx_dl(vt[i].ptr)] = vt[i].lo;
         mem_img[nx_dl(nx_dl(vt[i].ptr))] = vt[i].hi;
         gmode = vt[i].mode; gphase = 1'b0;
         do_dl();
         check("vec_ir", ir, vt[i].e_ir);
         check("vec_ir_valid_cnt", iv_cnt, 1);
         check("vec_dli_cnt", dli_cnt, 32'(vt[i].e_dli));
         check("vec_dlist_ptr", dlist_ptr, vt[i].e_ptr);
         check("vec_msr", msr, vt[i].e_msr);
         check("vec_wait_vbl", wait_vbl, vt[i].e_wait);
         check("vec_nfetch", fetch_log.size(), vt[i].e_nf);
         if (fetch_log.size() > 0) begin
            check("vec_first_addr", fetch_log[0], vt[i].ptr);
            check("vec_last_addr", fetch_log[fetch_log.size()-1], vt[i].e_last);
         end
      end

      // JVB pending: start_dl ignored, start_line still served, vblank releases
      gmode = 1;
      clear_obs();
      start_dl = 1'b1; step(); start_dl = 1'b0;
      repeat (3) step();
      check("jvb_block_busy", busy, 0);
      check("jvb_block_nfetch", fetch_log.size(), 0);
      check("jvb_block_ptr", dlist_ptr, 16'h3000);
      four = '{16'h4FFE, 16'h4FFF, 16'h4000, 16'h4001};
      do_line(4);
      exp_addrs.delete();
      foreach (four[i]) exp_addrs.push_back(four[i]);
      check_log("msr_wrap");
      check("msr_wrap_msr", msr, 16'h4002);
      check("msr_wrap_line_done", ld_cnt, 1);
      check("jvb_still_waiting", wait_vbl, 1);
      vblank = 1'b1; step(); vblank = 1'b0;
      check("vblank_clears_wait", wait_vbl, 0);
      mem_img[16'h3000] = 8'h02;
      do_dl();
      check("after_vbl_nfetch", fetch_log.size(), 1);
      if (fetch_log.size() > 0) check("after_vbl_addr", fetch_log[0], 16'h3000);
      check("after_vbl_ptr", dlist_ptr, 16'h3001);

      // 40-byte line with data = index
      for (int k = 0; k < 40; k++) mem_img[16'h4002 + k] = 8'(k);
      do_line(40);
      check("line40_nfetch", fetch_log.size(), 40);
      check("line40_done_cnt", ld_cnt, 1);
      check("line40_msr", msr, 16'h402A);
      for (int k = 0; k < 40; k++) begin
         read_buf(k, d);
         check("line40_buf", d, 8'(k));
      end

      gmode = 3;
      do_line(100);
      check("line100_nfetch", fetch_log.size(), 48);
      check("line100_msr", msr, 16'h405A);
      read_buf(0, d);
      check("line100_buf0", d, mem_img[16'h402A]);
      read_buf(47, d);
      check("line100_buf47", d, mem_img[16'h4059]);

      do_line(0);
      check("line0_nfetch", fetch_log.size(), 0);
      check("line0_done_cnt", ld_cnt, 1);
      check("line0_msr", msr, 16'h405A);

      // start_dl and start_line together: display list wins
      gmode = 1;
      load_ptr(16'h2100);
      mem_img[16'h2100] = 8'h02;
      clear_obs();
      line_bytes = 7'd5;
      start_dl = 1'b1; start_line = 1'b1;
      step();
      start_dl = 1'b0; start_line = 1'b0;
      wait_idle(100);
      check("collide_nfetch", fetch_log.size(), 1);
      check("collide_ptr", dlist_ptr, 16'h2101);
      check("collide_line_done", ld_cnt, 0);
      check("collide_msr", msr, 16'h405A);

      // dlist_load while the JMP low byte is outstanding overrides the jump target
      load_ptr(16'h2200);
      mem_img[16'h2200] = 8'h01; mem_img[16'h2201] = 8'h00; mem_img[16'h2202] = 8'h50;
      gmode = 2; gphase = 1'b0;
      clear_obs();
      start_dl = 1'b1; step(); start_dl = 1'b0;
      n = 0;
      while (fetch_log.size() < 1 && n < 50) begin step(); n++; end
      check("jmp_first_grant_seen", fetch_log.size(), 1);
      dlist_load = 1'b1; dlist_init = 16'h6000;
      step();
      dlist_load = 1'b0;
      wait_idle(100);
      check("pend_load_ptr", dlist_ptr, 16'h6000);
      check("pend_load_nfetch", fetch_log.size(), 3);
      check("pend_load_ir_valid", iv_cnt, 1);

      // reset in the middle of a line fetch
      gmode = 1;
      line_bytes = 7'd20;
      start_line = 1'b1; step(); start_line = 1'b0;
      repeat (5) step();
      rst = 1'b1; step();
      check("midrst_mem_req", mif.mem_req, 0);
      check("midrst_msr", msr, 0);
      check("midrst_busy", busy, 0);
      check("midrst_ptr", dlist_ptr, 0);
      rst = 1'b0;
      step();

      // randomized traffic against the reference model
      mptr = '0; mmsr = '0; mwait = 1'b0;
      gmode = 3;
      for (int it = 0; it < 40; it++) begin
         sel = int'($urandom_range(0, 5));
         if (sel == 0) begin
            load_ptr(16'($urandom));
            mptr = dlist_init; mwait = 1'b0;
         end
         if (sel <= 3) begin
            if (mwait) begin
               vblank = 1'b1; step(); vblank = 1'b0;
               mwait = 1'b0;
            end
            op = 8'($urandom);
            case ($urandom_range(0, 3))
               0:       op = {op[7:4], 4'd1};
               1:       op = {op[7], 1'b1, op[5:4], 4'(2 + $urandom_range(0, 13))};
               default: ;
            endcase
            mem_img[mptr] = op;
            mem_img[nx_dl(mptr)] = 8'($urandom);
            mem_img[nx_dl(nx_dl(mptr))] = 8'($urandom);
            model_dl(op);
            do_dl();
            check("rnd_ir", ir, op);
            check("rnd_ir_valid_cnt", iv_cnt, 1);
            check("rnd_dli_cnt", dli_cnt, 32'(op[7]));
            check_log("rnd_dl");
         end else begin
            len = int'($urandom_range(0, 60));
            model_line(len);
            do_line(len);
            check_log("rnd_line");
            check("rnd_line_done", ld_cnt, 1);
            for (int k = 0; k < exp_addrs.size(); k++) begin
               read_buf(k, d);
               check("rnd_buf", d, exp_buf[k]);
            end
         end
         check("rnd_ptr", dlist_ptr, mptr);
         check("rnd_msr", msr, mmsr);
         check("rnd_wait_vbl", wait_vbl, mwait);
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
